// File: rtl/reg_dump_unit.sv
// Walks a block of register-file entries through a synchronous read port and streams each
// {addr, data} pair out on a valid/ready channel, buffered by a 2-entry skid FIFO.
module reg_dump_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned START_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned       CntW     = $clog2(NUM_REGS + 1);
  localparam logic [CntW-1:0]   LastIdx  = CntW'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(START_ADDR);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CntW-1:0]   accept_cnt_q, accept_cnt_d;
  logic              inflight_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] buf_addr_q [2];
  logic [DATA_W-1:0] buf_data_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        buf_cnt_q, buf_cnt_d;
  logic [1:0]        occupancy;
  logic [ADDR_W-1:0] issue_addr;
  logic              push, pop;

  assign push       = inflight_q;
  assign out_valid  = (buf_cnt_q != 2'd0);
  assign pop        = out_valid & out_ready;
  assign out_addr   = buf_addr_q[rd_ptr_q];
  assign out_data   = buf_data_q[rd_ptr_q];
  assign out_last   = out_valid & (accept_cnt_q == LastIdx);
  assign issue_addr = BaseAddr + ADDR_W'(issue_cnt_q);
  assign rd_addr    = rd_en ? issue_addr : rd_addr_q;

  // Occupancy counts the beat leaving this cycle, so a streaming sink sustains 1 beat/cycle
  // while the FIFO plus the in-flight read can never exceed two entries.
  assign occupancy  = buf_cnt_q + {1'b0, inflight_q} - {1'b0, pop};

  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    accept_cnt_d = accept_cnt_q;
    rd_en        = 1'b0;
    done         = 1'b0;
    busy         = (state_q != StIdle);
    if (pop) begin
      accept_cnt_d = accept_cnt_q + CntW'(1);
    end
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StRun;
          issue_cnt_d  = '0;
          accept_cnt_d = '0;
        end
      end
      StRun: begin
        rd_en = (occupancy < 2'd2);
        if (rd_en) begin
          issue_cnt_d = issue_cnt_q + CntW'(1);
          if (issue_cnt_q == LastIdx) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (pop && (accept_cnt_q == LastIdx)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    buf_cnt_d = buf_cnt_q;
    unique case ({push, pop})
      2'b10:   buf_cnt_d = buf_cnt_q + 2'd1;
      2'b01:   buf_cnt_d = buf_cnt_q - 2'd1;
      default: buf_cnt_d = buf_cnt_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      issue_cnt_q  <= '0;
      accept_cnt_q <= '0;
      inflight_q   <= 1'b0;
      rd_addr_q    <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      buf_cnt_q    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_addr_q[i] <= '0;
        buf_data_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      accept_cnt_q <= accept_cnt_d;
      inflight_q   <= rd_en;
      buf_cnt_q    <= buf_cnt_d;
      if (rd_en) begin
        rd_addr_q <= issue_addr;
      end
      // rd_addr_q still holds the address of the read whose data is arriving now
      if (push) begin
        buf_addr_q[wr_ptr_q] <= rd_addr_q;
        buf_data_q[wr_ptr_q] <= rd_data;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule
